// File: rtl/imem_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_program_loader_if
//  Purpose  : Bundles the host-side byte stream (with its session request) and
//             the instruction-memory write port of the program loader.
//  Ports    : load_req          - one-cycle request to begin a load session
//             s_valid/s_data    - stream byte and its valid
//             s_ready           - loader accepts the byte this cycle
//             LOAD_PROGRAM_CTRL - one-cycle instruction-memory write strobe
//             LOAD_PROGRAM_ADDR - write address (byte addressed)
//             LOAD_PROGRAM_DATA - 32-bit write data
//  Modports : master - host / stream source side
//             slave  - loader side
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_program_loader_if #(
  parameter int ADDR_W = 20
);
  logic              load_req;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              LOAD_PROGRAM_CTRL;
  logic [ADDR_W-1:0] LOAD_PROGRAM_ADDR;
  logic [31:0]       LOAD_PROGRAM_DATA;

  modport master (
    output load_req, s_valid, s_data,
    input  s_ready, LOAD_PROGRAM_CTRL, LOAD_PROGRAM_ADDR, LOAD_PROGRAM_DATA
  );

  modport slave (
    input  load_req, s_valid, s_data,
    output s_ready, LOAD_PROGRAM_CTRL, LOAD_PROGRAM_ADDR, LOAD_PROGRAM_DATA
  );
endinterface
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_program_loader
//  Purpose  : Receives a byte stream framed as N (4 bytes) + N payload words +
//             XOR checksum (4 bytes), all little-endian, writes each payload
//             word into instruction memory and pulses START when the checksum
//             matches.
//  Ports    : CLK, RST      - clock, synchronous active-high reset
//             bus (slave)   - load_req, byte stream, memory write port
//             busy          - session in progress (HDR, DATA, WRITE, CSUM)
//             done          - sticky: last session completed with good checksum
//             error         - sticky: last session failed
//             START         - one-cycle pulse on entry to DONE
//             words_loaded  - words written in the current/last session
//  Revision : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 4,
  parameter int MAX_WORDS = 1024
) (
  input  logic                        CLK,
  input  logic                        RST,
  imem_program_loader_if.slave        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        START,
  output logic [15:0]                 words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;      // bytes 0..2 of the word being assembled
  logic [15:0]       n_words;
  logic [31:0]       acc;
  logic [ADDR_W-1:0] next_addr;  // address the next payload word goes to

  logic        xfer;
  logic        last_byte;
  logic [31:0] word_full;

  // s_ready and busy are pure decodes of the state register, so they are
  // glitch-free and settle right after the clock edge.
  assign bus.s_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign busy        = bus.s_ready || (state == S_WRITE);

  assign xfer      = bus.s_valid && bus.s_ready;
  assign last_byte = (byte_cnt == 2'd3);
  // The 4th byte arrives last and forms the most significant byte.
  assign word_full = {bus.s_data, shreg};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                 <= S_IDLE;
      byte_cnt              <= '0;
      shreg                 <= '0;
      n_words               <= '0;
      acc                   <= '0;
      next_addr             <= '0;
      words_loaded          <= '0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      START                 <= 1'b0;
      bus.LOAD_PROGRAM_CTRL <= 1'b0;
      bus.LOAD_PROGRAM_ADDR <= '0;
      bus.LOAD_PROGRAM_DATA <= '0;
    end else begin
      START                 <= 1'b0;
      bus.LOAD_PROGRAM_CTRL <= 1'b0;

      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= word_full[31:8];
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.load_req) begin
            state        <= S_HDR;
            byte_cnt     <= '0;
            acc          <= '0;
            words_loaded <= '0;
            next_addr    <= ADDR_W'(BASE_ADDR);
            done         <= 1'b0;
            error        <= 1'b0;
          end
        end

        S_HDR: begin
          if (xfer && last_byte) begin
            if (word_full > 32'(MAX_WORDS)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              n_words <= word_full[15:0];
              state   <= (word_full == 32'd0) ? S_CSUM : S_DATA;
            end
          end
        end

        S_DATA: begin
          // Strobe, address and data are launched together so they are all
          // valid during the single WRITE cycle.
          if (xfer && last_byte) begin
            state                 <= S_WRITE;
            bus.LOAD_PROGRAM_CTRL <= 1'b1;
            bus.LOAD_PROGRAM_ADDR <= next_addr;
            bus.LOAD_PROGRAM_DATA <= word_full;
          end
        end

        S_WRITE: begin
          acc          <= acc ^ bus.LOAD_PROGRAM_DATA;
          next_addr    <= next_addr + ADDR_W'(ADDR_STEP);
          words_loaded <= words_loaded + 16'd1;
          state        <= (words_loaded + 16'd1 == n_words) ? S_CSUM : S_DATA;
        end

        S_CSUM: begin
          if (xfer && last_byte) begin
            if (word_full == acc) begin
              state <= S_DONE;
              done  <= 1'b1;
              START <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
